// File: rtl/truth_table_sweeper_pkg.sv
// Shared types for the truth-table sweeper: FSM encoding and count width.
// Optional build macro SWEEPER_CAPTURE_EN adds the observed-table port.
package sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // err_count must hold 0..2^n inclusive
    function automatic int cnt_w(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Sweeper control/result bundle; master = sweeper, slave = user side.
// SWEEPER_CAPTURE_EN adds the observed truth table.
interface truth_table_sweeper_if
    import sweeper_pkg::*;
#(
    parameter int N = 4
);

    logic                  start;
    logic                  f_dut;
    logic [N-1:0]          x;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [cnt_w(N)-1:0]   err_count;
    logic [N-1:0]          first_err_idx;
`ifdef SWEEPER_CAPTURE_EN
    logic [2**N-1:0]       observed;

    modport master (
        input  start, f_dut,
        output x, busy, done, pass,
        output err_count, first_err_idx, observed
    );

    modport slave (
        output start, f_dut,
        input  x, busy, done, pass,
        input  err_count, first_err_idx, observed
    );
`else
    modport master (
        input  start, f_dut,
        output x, busy, done, pass,
        output err_count, first_err_idx
    );

    modport slave (
        output start, f_dut,
        input  x, busy, done, pass,
        input  err_count, first_err_idx
    );
`endif

endinterface

// File: rtl/truth_table_sweeper_hold_ctr.sv
// Per-vector hold counter: counts 0..HOLD-1 while enabled, flags last cycle.
// Built the same with or without SWEEPER_CAPTURE_EN.
module sweep_hold_ctr #(
    parameter int HOLD = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int CNTW = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;

    assign last = (cnt_q == CNTW'(HOLD - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = last ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive sweeper for an N-input combinational block vs a golden table.
// Define SWEEPER_CAPTURE_EN to also record every sampled f_dut bit.
module truth_table_sweeper
    import sweeper_pkg::*;
#(
    parameter int              N      = 4,
    parameter int              HOLD   = 5,
    parameter logic [2**N-1:0] GOLDEN = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_sweeper_if.master bus
);

    localparam int           CW   = cnt_w(N);
    localparam logic [N-1:0] XMAX = '1;

    state_t          state_q;
    logic [N-1:0]    x_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [CW-1:0]   err_q;
    logic [CW-1:0]   err_d;
    logic [N-1:0]    fidx_q;
    logic            mis_d;
    logic            clr;
    logic            en;
    logic            last;

    assign clr   = (state_q == IDLE) && bus.start;
    assign en    = (state_q == DRIVE);
    assign mis_d = (bus.f_dut != GOLDEN[x_q]);
    assign err_d = err_q + CW'(mis_d);

    sweep_hold_ctr #(
        .HOLD (HOLD)
    ) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (en),
        .last  (last)
    );

`ifdef SWEEPER_CAPTURE_EN
    logic [2**N-1:0] obs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            obs_q <= '0;
        else if (clr)
            obs_q <= '0;
        else if (en && last)
            obs_q[x_q] <= bus.f_dut;
    end

    assign bus.observed = obs_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fidx_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= DRIVE;
                        x_q     <= '0;
                        busy_q  <= 1'b1;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        fidx_q  <= '0;
                    end
                end
                DRIVE: begin
                    if (last) begin
                        err_q <= err_d;
                        if (mis_d && (err_q == '0))
                            fidx_q <= x_q;
                        if (x_q == XMAX) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == '0);
                        end else begin
                            x_q <= x_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.x             = x_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.err_count     = err_q;
    assign bus.first_err_idx = fidx_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: N=4/HOLD=5 sweeper against selectable DUT functions,
// plus an N=2/HOLD=1 XOR sweeper.
module tb_truth_table_sweeper;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    truth_table_sweeper_if #(.N(4)) bus4 ();
    truth_table_sweeper_if #(.N(2)) bus2 ();

    truth_table_sweeper #(
        .N      (4),
        .HOLD   (5),
        .GOLDEN (16'h8000)
    ) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    truth_table_sweeper #(
        .N      (2),
        .HOLD   (1),
        .GOLDEN (4'b0110)
    ) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    // 0 AND4, 1 OR4, 2 const 0, 3 XOR4
    int sel;

    always_comb begin
        bus4.f_dut = 1'b0;
        case (sel)
            0: bus4.f_dut = &bus4.x;
            1: bus4.f_dut = |bus4.x;
            3: bus4.f_dut = ^bus4.x;
            default: bus4.f_dut = 1'b0;
        endcase
    end

    assign bus2.f_dut = ^bus2.x;

    typedef struct {
        int          sel;
        int          err;
        int          fidx;
        int          pass;
        logic [15:0] obs;
    } vec_t;

    vec_t tbl [4];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic launch4();
        bus4.start = 1'b1;
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
    endtask

    // returns edges after E0 until done is seen, -1 on timeout
    task automatic wait_done4(input bit pulse, output int cyc);
        cyc = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            bus4.start = pulse && (c == 16 || c == 39);
            if (bus4.done) begin
                cyc = c;
                break;
            end
        end
        bus4.start = 1'b0;
    endtask

    initial begin
        int cyc;
        int seen;

        tbl[0] = '{sel: 0, err: 0,  fidx: 0,  pass: 1, obs: 16'h8000};
        tbl[1] = '{sel: 1, err: 14, fidx: 1,  pass: 0, obs: 16'hFFFE};
        tbl[2] = '{sel: 2, err: 1,  fidx: 15, pass: 0, obs: 16'h0000};
        tbl[3] = '{sel: 3, err: 9,  fidx: 1,  pass: 0, obs: 16'h6996};

        sel        = 0;
        bus4.start = 1'b0;
        bus2.start = 1'b0;
        rst_n      = 1'b1;
        #2 rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x",    32'(bus4.x), 0);
        chk("rst_busy", 32'(bus4.busy), 0);
        chk("rst_done", 32'(bus4.done), 0);
        chk("rst_pass", 32'(bus4.pass), 0);
        chk("rst_err",  32'(bus4.err_count), 0);
        chk("rst_fidx", 32'(bus4.first_err_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            sel = tbl[i].sel;
            launch4();
            chk("start_busy", 32'(bus4.busy), 1);
            chk("start_x",    32'(bus4.x), 0);
            chk("start_pass", 32'(bus4.pass), 0);
            wait_done4(1'b0, cyc);
            chk("done_edge", 32'(cyc), 80);
            chk("err_count", 32'(bus4.err_count), 32'(tbl[i].err));
            chk("first_idx", 32'(bus4.first_err_idx), 32'(tbl[i].fidx));
            chk("pass",      32'(bus4.pass), 32'(tbl[i].pass));
            chk("x_hold",    32'(bus4.x), 15);
            chk("busy_end",  32'(bus4.busy), 0);
`ifdef SWEEPER_CAPTURE_EN
            chk("observed",  32'(bus4.observed), 32'(tbl[i].obs));
`endif
            @(posedge clk);
            #1;
            chk("done_fall", 32'(bus4.done), 0);
        end

        // start pulses mid-sweep are ignored and not queued
        sel = 0;
        launch4();
        wait_done4(1'b1, cyc);
        chk("ign_done_edge", 32'(cyc), 80);
        chk("ign_pass", 32'(bus4.pass), 1);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (bus4.done || bus4.busy) seen++;
        end
        chk("ign_no_requeue", 32'(seen), 0);

        // reset in the middle of vector 7
        sel = 1;
        launch4();
        repeat (36) @(posedge clk);
        #1;
        chk("mid_x",   32'(bus4.x), 7);
        chk("mid_err", 32'(bus4.err_count), 6);
        rst_n = 1'b0;
        #1;
        chk("abort_x",    32'(bus4.x), 0);
        chk("abort_busy", 32'(bus4.busy), 0);
        chk("abort_err",  32'(bus4.err_count), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (bus4.done || bus4.busy) seen++;
        end
        chk("abort_no_done", 32'(seen), 0);
        sel = 0;
        launch4();
        wait_done4(1'b0, cyc);
        chk("rerun_done_edge", 32'(cyc), 80);
        chk("rerun_pass", 32'(bus4.pass), 1);

        // back-to-back: start on the first edge it can be accepted
        @(posedge clk);
        #1;
        sel = 2;
        launch4();
        chk("b2b_busy", 32'(bus4.busy), 1);
        chk("b2b_pass_clr", 32'(bus4.pass), 0);
        wait_done4(1'b0, cyc);
        chk("b2b_done_edge", 32'(cyc), 80);
        chk("b2b_err",  32'(bus4.err_count), 1);
        chk("b2b_fidx", 32'(bus4.first_err_idx), 15);
        chk("b2b_pass", 32'(bus4.pass), 0);

        // N=2, HOLD=1 XOR sweep
        @(posedge clk);
        #1;
        bus2.start = 1'b1;
        @(posedge clk);
        #1;
        bus2.start = 1'b0;
        chk("h1_busy", 32'(bus2.busy), 1);
        chk("h1_x0",   32'(bus2.x), 0);
        for (int k = 1; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("h1_x",    32'(bus2.x), 32'(k));
            chk("h1_done", 32'(bus2.done), 0);
        end
        @(posedge clk);
        #1;
        chk("h1_done_edge", 32'(bus2.done), 1);
        chk("h1_pass",      32'(bus2.pass), 1);
        chk("h1_err",       32'(bus2.err_count), 0);
        chk("h1_busy_end",  32'(bus2.busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
